// File: rtl/cpu_boot_sequencer.sv
// rtl/cpu_boot_sequencer.sv - boot table loader, PC set and watchdog-supervised run controller
module cpu_boot_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PC_WIDTH       = 32,
    parameter int NUM_INIT       = 4,
    parameter logic [((NUM_INIT > 0) ? NUM_INIT : 1)*REG_ADDR_WIDTH-1:0] INIT_ADDRS = {5'd8, 5'd5, 5'd2, 5'd1},
    parameter logic [((NUM_INIT > 0) ? NUM_INIT : 1)*DATA_WIDTH-1:0]     INIT_DATA  = {32'd3, 32'd5, 32'd5, 32'd7},
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter bit AUTO_BOOT      = 1'b1,
    parameter int WD_WIDTH       = 16,
    parameter int WD_LIMIT       = 1000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      go,
    input  logic                      halt,
    output logic                      rf_write,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_sel,
    output logic [DATA_WIDTH-1:0]     rf_write_data,
    output logic                      pc_load,
    output logic [PC_WIDTH-1:0]       pc_load_value,
    output logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [WD_WIDTH-1:0]       cycle_count
);

    // A zero-entry table still gets one dummy slot so the arrays stay legal.
    localparam int NT    = (NUM_INIT > 0) ? NUM_INIT : 1;
    localparam int IDX_W = (NT > 1) ? $clog2(NT) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NT - 1);
    localparam logic [WD_WIDTH-1:0] WD_LAST  = WD_WIDTH'((WD_LIMIT > 0) ? WD_LIMIT - 1 : 0);
    localparam bit HAS_INIT = (NUM_INIT > 0);
    localparam bit WD_EN    = (WD_LIMIT != 0);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PCSET, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WD_WIDTH-1:0] count_q, count_d;
    logic                timeout_q, timeout_d;

    logic [REG_ADDR_WIDTH-1:0] addr_tab [NT];
    logic [DATA_WIDTH-1:0]     data_tab [NT];

    for (genvar g = 0; g < NT; g++) begin : g_tab
        assign addr_tab[g] = INIT_ADDRS[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign data_tab[g] = INIT_DATA[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // State, table index, run counter and timeout flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic; halt takes priority over the watchdog in the same cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (AUTO_BOOT || go) begin
                    state_d = HAS_INIT ? S_LOAD : S_PCSET;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (idx_q == LAST_IDX) state_d = S_PCSET;
                else                   idx_d   = idx_q + 1'b1;
            end
            S_PCSET: begin
                state_d = S_RUN;
                count_d = '0;
            end
            S_RUN: begin
                if (halt) begin
                    state_d   = S_DONE;
                    count_d   = count_q + 1'b1;
                    timeout_d = 1'b0;
                end else if (WD_EN && (count_q == WD_LAST)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_DONE: begin
                if (go) begin
                    state_d   = HAS_INIT ? S_LOAD : S_PCSET;
                    idx_d     = '0;
                    count_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rf_write      = (state_q == S_LOAD);
    assign rf_write_sel  = rf_write ? addr_tab[idx_q] : '0;
    assign rf_write_data = rf_write ? data_tab[idx_q] : '0;
    assign pc_load       = (state_q == S_PCSET);
    assign pc_load_value = RESET_VECTOR;
    assign start         = (state_q == S_RUN);
    assign busy          = (state_q == S_LOAD) || (state_q == S_PCSET) || (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign timeout       = timeout_q;
    assign cycle_count   = count_q;

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// tb/tb_cpu_boot_sequencer.sv - scoreboard bench for cpu_boot_sequencer
module tb_cpu_boot_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    // dut_a: defaults
    logic a_reset = 1'b1, a_go = 1'b0, a_halt = 1'b0;
    logic a_rf_write, a_pc_load, a_start, a_busy, a_done, a_timeout;
    logic [4:0] a_sel; logic [31:0] a_data, a_pcv; logic [15:0] a_cnt;
    // dut_b: WD_LIMIT=20
    logic b_reset = 1'b1, b_go = 1'b0, b_halt = 1'b0;
    logic b_rf_write, b_pc_load, b_start, b_busy, b_done, b_timeout;
    logic [4:0] b_sel; logic [31:0] b_data, b_pcv; logic [15:0] b_cnt;
    // dut_c: WD_LIMIT=5
    logic c_reset = 1'b1, c_go = 1'b0, c_halt = 1'b0;
    logic c_rf_write, c_pc_load, c_start, c_busy, c_done, c_timeout;
    logic [4:0] c_sel; logic [31:0] c_data, c_pcv; logic [15:0] c_cnt;
    // dut_d: NUM_INIT=0, AUTO_BOOT=0
    logic d_reset = 1'b1, d_go = 1'b0, d_halt = 1'b0;
    logic d_rf_write, d_pc_load, d_start, d_busy, d_done, d_timeout;
    logic [4:0] d_sel; logic [31:0] d_data, d_pcv; logic [15:0] d_cnt;

    cpu_boot_sequencer dut_a (
        .clock(clock), .reset(a_reset), .go(a_go), .halt(a_halt),
        .rf_write(a_rf_write), .rf_write_sel(a_sel), .rf_write_data(a_data),
        .pc_load(a_pc_load), .pc_load_value(a_pcv), .start(a_start), .busy(a_busy),
        .done(a_done), .timeout(a_timeout), .cycle_count(a_cnt));

    cpu_boot_sequencer #(.WD_LIMIT(20)) dut_b (
        .clock(clock), .reset(b_reset), .go(b_go), .halt(b_halt),
        .rf_write(b_rf_write), .rf_write_sel(b_sel), .rf_write_data(b_data),
        .pc_load(b_pc_load), .pc_load_value(b_pcv), .start(b_start), .busy(b_busy),
        .done(b_done), .timeout(b_timeout), .cycle_count(b_cnt));

    cpu_boot_sequencer #(.WD_LIMIT(5)) dut_c (
        .clock(clock), .reset(c_reset), .go(c_go), .halt(c_halt),
        .rf_write(c_rf_write), .rf_write_sel(c_sel), .rf_write_data(c_data),
        .pc_load(c_pc_load), .pc_load_value(c_pcv), .start(c_start), .busy(c_busy),
        .done(c_done), .timeout(c_timeout), .cycle_count(c_cnt));

    cpu_boot_sequencer #(.NUM_INIT(0), .INIT_ADDRS('0), .INIT_DATA('0), .AUTO_BOOT(1'b0)) dut_d (
        .clock(clock), .reset(d_reset), .go(d_go), .halt(d_halt),
        .rf_write(d_rf_write), .rf_write_sel(d_sel), .rf_write_data(d_data),
        .pc_load(d_pc_load), .pc_load_value(d_pcv), .start(d_start), .busy(d_busy),
        .done(d_done), .timeout(d_timeout), .cycle_count(d_cnt));

    // Expected register-file writes, in index order
    task automatic push_table();
        exp_q.push_back('{5'd1, 32'd7});
        exp_q.push_back('{5'd2, 32'd5});
        exp_q.push_back('{5'd5, 32'd5});
        exp_q.push_back('{5'd8, 32'd3});
    endtask

    // Scoreboard consumer for dut_a writes
    always @(negedge clock) begin
        if (a_rf_write === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected_write sel=%0d data=%0d required=no write", a_sel, a_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (a_sel !== mon_e.sel || a_data !== mon_e.data) begin
                    bad++;
                    $display("FAIL a_write got=(%0d,%0d) required=(%0d,%0d)", a_sel, a_data, mon_e.sel, mon_e.data);
                end
            end
        end else if (!a_reset) begin
            total++;
            if (a_sel !== 5'd0 || a_data !== 32'd0) begin
                bad++;
                $display("FAIL a_idle_write_bus sel=%0d data=%0d required=0,0", a_sel, a_data);
            end
        end
    end

    task automatic test_reset();
        @(negedge clock);
        total++;
        if ({a_rf_write, a_pc_load, a_start, a_busy, a_done, a_timeout} !== 6'd0 || a_cnt !== 16'd0 ||
            a_sel !== 5'd0 || a_data !== 32'd0 || a_pcv !== 32'd0) begin
            bad++;
            $display("FAIL reset_a flags=%b cnt=%0d pcv=%0d required=0", {a_rf_write, a_pc_load, a_start, a_busy, a_done, a_timeout}, a_cnt, a_pcv);
        end
        total++;
        if ({d_rf_write, d_pc_load, d_start, d_busy, d_done, d_timeout} !== 6'd0 || d_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_d flags=%b cnt=%0d required=0", {d_rf_write, d_pc_load, d_start, d_busy, d_done, d_timeout}, d_cnt);
        end
    endtask

    // Expects a reboot on dut_a whose go/reset-release was the previous edge
    task automatic check_boot_a(input string name);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            total++;
            if (k <= 4 && (a_rf_write !== 1'b1 || a_busy !== 1'b1 || a_pc_load !== 1'b0)) begin
                bad++;
                $display("FAIL %s_load k=%0d wr=%b busy=%b pcl=%b required=1,1,0", name, k, a_rf_write, a_busy, a_pc_load);
            end else if (k == 5 && (a_pc_load !== 1'b1 || a_rf_write !== 1'b0 || a_pcv !== 32'd0 || a_start !== 1'b0)) begin
                bad++;
                $display("FAIL %s_pcset pcl=%b wr=%b pcv=%0d start=%b required=1,0,0,0", name, a_pc_load, a_rf_write, a_pcv, a_start);
            end else if (k == 6 && (a_start !== 1'b1 || a_pc_load !== 1'b0 || a_cnt !== 16'd0)) begin
                bad++;
                $display("FAIL %s_run start=%b pcl=%b cnt=%0d required=1,0,0", name, a_start, a_pc_load, a_cnt);
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_writes_left got=%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic test_boot();
        a_reset = 1'b0;
        push_table();
        check_boot_a("boot");
    endtask

    task automatic test_halt();
        // now in RUN cycle 1; move to RUN cycle 10
        repeat (9) @(negedge clock);
        total++;
        if (a_cnt !== 16'd9 || a_start !== 1'b1) begin
            bad++;
            $display("FAIL halt_pre cnt=%0d start=%b required=9,1", a_cnt, a_start);
        end
        a_halt = 1'b1;
        @(negedge clock);
        a_halt = 1'b0;
        total++;
        if (a_done !== 1'b1 || a_timeout !== 1'b0 || a_start !== 1'b0 || a_busy !== 1'b0 || a_cnt !== 16'd10) begin
            bad++;
            $display("FAIL halt_done done=%b to=%b start=%b busy=%b cnt=%0d required=1,0,0,0,10", a_done, a_timeout, a_start, a_busy, a_cnt);
        end
        a_halt = 1'b1;
        @(negedge clock);
        a_halt = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if (a_done !== 1'b1 || a_cnt !== 16'd10 || a_start !== 1'b0) begin
            bad++;
            $display("FAIL halt_hold done=%b cnt=%0d start=%b required=1,10,0", a_done, a_cnt, a_start);
        end
    endtask

    task automatic test_reboot_and_reset_mid_load();
        a_go = 1'b1;
        push_table();
        @(negedge clock);
        a_go = 1'b0;
        total++;
        if (a_done !== 1'b0 || a_cnt !== 16'd0 || a_timeout !== 1'b0 || a_rf_write !== 1'b1) begin
            bad++;
            $display("FAIL reboot done=%b cnt=%0d to=%b wr=%b required=0,0,0,1", a_done, a_cnt, a_timeout, a_rf_write);
        end
        @(negedge clock);  // second LOAD cycle
        #2 a_reset = 1'b1;
        #1;
        total++;
        if ({a_rf_write, a_pc_load, a_start, a_busy, a_done, a_timeout} !== 6'd0 || a_sel !== 5'd0 ||
            a_data !== 32'd0 || a_cnt !== 16'd0 || a_pcv !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_load flags=%b sel=%0d data=%0d required=0", {a_rf_write, a_pc_load, a_start, a_busy, a_done, a_timeout}, a_sel, a_data);
        end
        exp_q.delete();
        @(negedge clock);
        a_reset = 1'b0;
        push_table();
        check_boot_a("restart");
    endtask

    task automatic test_watchdog();
        int runs = 0;
        int guard = 0;
        b_reset = 1'b0;
        while (b_start !== 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        while (b_start === 1'b1 && runs < 100) begin
            runs++;
            @(negedge clock);
        end
        total++;
        if (runs != 20) begin
            bad++;
            $display("FAIL wd_run_len got=%0d required=20", runs);
        end
        total++;
        if (b_done !== 1'b1 || b_timeout !== 1'b1 || b_cnt !== 16'd19 || b_busy !== 1'b0) begin
            bad++;
            $display("FAIL wd_done done=%b to=%b cnt=%0d busy=%b required=1,1,19,0", b_done, b_timeout, b_cnt, b_busy);
        end
    endtask

    task automatic test_coincident();
        int guard = 0;
        c_reset = 1'b0;
        while (c_start !== 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        repeat (4) @(negedge clock);
        total++;
        if (c_start !== 1'b1 || c_cnt !== 16'd4) begin
            bad++;
            $display("FAIL coinc_pre start=%b cnt=%0d required=1,4", c_start, c_cnt);
        end
        c_halt = 1'b1;
        @(negedge clock);
        c_halt = 1'b0;
        total++;
        if (c_done !== 1'b1 || c_timeout !== 1'b0 || c_start !== 1'b0 || c_cnt !== 16'd5) begin
            bad++;
            $display("FAIL coinc_done done=%b to=%b start=%b cnt=%0d required=1,0,0,5", c_done, c_timeout, c_start, c_cnt);
        end
    endtask

    task automatic test_no_init();
        d_reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            total++;
            if (d_busy !== 1'b0 || d_rf_write !== 1'b0 || d_start !== 1'b0 || d_done !== 1'b0 || d_pc_load !== 1'b0) begin
                bad++;
                $display("FAIL noinit_idle busy=%b wr=%b start=%b done=%b pcl=%b required=0", d_busy, d_rf_write, d_start, d_done, d_pc_load);
            end
        end
        d_go = 1'b1;
        @(negedge clock);
        d_go = 1'b0;
        total++;
        if (d_pc_load !== 1'b1 || d_rf_write !== 1'b0 || d_busy !== 1'b1 || d_start !== 1'b0) begin
            bad++;
            $display("FAIL noinit_pcset pcl=%b wr=%b busy=%b start=%b required=1,0,1,0", d_pc_load, d_rf_write, d_busy, d_start);
        end
        @(negedge clock);
        total++;
        if (d_start !== 1'b1 || d_pc_load !== 1'b0 || d_cnt !== 16'd0) begin
            bad++;
            $display("FAIL noinit_run start=%b pcl=%b cnt=%0d required=1,0,0", d_start, d_pc_load, d_cnt);
        end
        d_go = 1'b1;
        @(negedge clock);
        d_go = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (d_start !== 1'b1 || d_pc_load !== 1'b0 || d_rf_write !== 1'b0 || d_cnt !== 16'(k)) begin
                bad++;
                $display("FAIL noinit_go_in_run k=%0d start=%b pcl=%b wr=%b cnt=%0d required=1,0,0,%0d", k, d_start, d_pc_load, d_rf_write, d_cnt, k);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_halt();
        test_reboot_and_reset_mid_load();
        test_watchdog();
        test_coincident();
        test_no_init();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
